// File: rtl/prbs_uart_checker.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// prbs_uart_checker
//   Receive end of the pseudo-random UART link. Deserialises 8N1 UART, accepts
//   ASCII '0'/'1' as sequence bits and self-synchronises a replica of the
//   11-bit XNOR LFSR sequence, counting checked bits, bit errors and bad chars.
//
// Ports:
//   clk             system clock
//   rst             asynchronous active-high reset (synchronous release)
//   i_rx_serial     UART line, idle high, asynchronous to clk
//   o_rx_dv         one-cycle pulse: byte received with valid stop bit
//   o_rx_byte       last received byte, held until next o_rx_dv
//   o_locked        checker synchronised to the sequence
//   o_err_pulse     one-cycle pulse per detected bit error
//   o_bits_checked  bits compared while locked (saturating)
//   o_bit_errors    mismatches while locked (saturating)
//   o_bad_chars     framing errors plus non-'0'/'1' bytes (saturating)
// -----------------------------------------------------------------------------
module prbs_uart_checker #(
  parameter int CLKS_PER_BIT = 217,
  parameter int LOSS_THRESH  = 4,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_rx_serial,
  output logic             o_rx_dv,
  output logic [7:0]       o_rx_byte,
  output logic             o_locked,
  output logic             o_err_pulse,
  output logic [CNT_W-1:0] o_bits_checked,
  output logic [CNT_W-1:0] o_bit_errors,
  output logic [CNT_W-1:0] o_bad_chars
);

  localparam int            TW        = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] HALF_CNT  = TW'(CLKS_PER_BIT / 2);
  localparam logic [TW-1:0] LAST_CNT  = TW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    LOSS_CNT  = 4'(LOSS_THRESH);
  localparam logic [3:0]    FILL_LAST = 4'd10;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_STOP      = 3'd3,
    RX_WAIT_IDLE = 3'd4
  } rx_state_t;

  typedef enum logic {
    CHK_HUNT   = 1'b0,
    CHK_LOCKED = 1'b1
  } chk_state_t;

  // Saturating add: counters stick at all ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val,
                                               input logic [1:0]       inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, val} + {{(CNT_W-1){1'b0}}, inc};
    if (sum[CNT_W]) begin
      return {CNT_W{1'b1}};
    end else begin
      return sum[CNT_W-1:0];
    end
  endfunction

  // Synchroniser
  logic rx_meta_q, rx_sync_q;

  // Receiver
  rx_state_t     rx_state_q, rx_state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic          rx_dv_q, rx_dv_d;
  logic          frame_err_s;

  // Checker
  chk_state_t       chk_state_q, chk_state_d;
  logic [10:0]      hist_q, hist_d;
  logic [3:0]       fill_q, fill_d;
  logic [3:0]       consec_q, consec_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] bits_checked_q, bits_checked_d;
  logic [CNT_W-1:0] bit_errors_q, bit_errors_d;
  logic [CNT_W-1:0] bad_chars_q, bad_chars_d;

  logic is_zero_s, is_one_s, accept_s, bad_byte_s, bit_r_s, pred_s;
  logic [1:0] bad_inc_s;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= i_rx_serial;
      rx_sync_q <= rx_meta_q;
    end
  end

  // Receiver next-state logic: start detect, mid-bit sampling, stop check.
  always_comb begin
    rx_state_d  = rx_state_q;
    tick_d      = tick_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_byte_d   = rx_byte_q;
    rx_dv_d     = 1'b0;
    frame_err_s = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        tick_d    = '0;
        bit_idx_d = 3'd0;
        if (!rx_sync_q) begin
          rx_state_d = RX_START;
        end else begin
          rx_state_d = RX_IDLE;
        end
      end
      RX_START: begin
        if (tick_q == HALF_CNT) begin
          // Re-check the start bit at its centre to reject line glitches.
          tick_d = '0;
          if (!rx_sync_q) begin
            rx_state_d = RX_DATA;
          end else begin
            rx_state_d = RX_IDLE;
          end
        end else begin
          tick_d = tick_q + {{(TW-1){1'b0}}, 1'b1};
        end
      end
      RX_DATA: begin
        if (tick_q == LAST_CNT) begin
          tick_d  = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            bit_idx_d  = 3'd0;
            rx_state_d = RX_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          tick_d = tick_q + {{(TW-1){1'b0}}, 1'b1};
        end
      end
      RX_STOP: begin
        if (tick_q == LAST_CNT) begin
          tick_d = '0;
          if (rx_sync_q) begin
            rx_byte_d  = shift_q;
            rx_dv_d    = 1'b1;
            rx_state_d = RX_IDLE;
          end else begin
            frame_err_s = 1'b1;
            rx_state_d  = RX_WAIT_IDLE;
          end
        end else begin
          tick_d = tick_q + {{(TW-1){1'b0}}, 1'b1};
        end
      end
      RX_WAIT_IDLE: begin
        // A low stop bit may be a break; do not resync until the line idles.
        if (rx_sync_q) begin
          rx_state_d = RX_IDLE;
        end else begin
          rx_state_d = RX_WAIT_IDLE;
        end
      end
      default: begin
        rx_state_d = RX_IDLE;
        tick_d     = '0;
        bit_idx_d  = 3'd0;
      end
    endcase
  end

  // Receiver state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_q <= RX_IDLE;
      tick_q     <= '0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'h00;
      rx_byte_q  <= 8'h00;
      rx_dv_q    <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      tick_q     <= tick_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      rx_byte_q  <= rx_byte_d;
      rx_dv_q    <= rx_dv_d;
    end
  end

  // '0' carries sequence bit 1 and '1' carries 0 (generator sends '0' on LSB=1).
  assign is_zero_s  = (rx_byte_q == 8'h30);
  assign is_one_s   = (rx_byte_q == 8'h31);
  assign accept_s   = rx_dv_q & (is_zero_s | is_one_s);
  assign bad_byte_s = rx_dv_q & ~(is_zero_s | is_one_s);
  assign bit_r_s    = is_zero_s;
  assign pred_s     = hist_q[9] ^ hist_q[6] ^ hist_q[3] ^ hist_q[0] ^ 1'b1;
  assign bad_inc_s  = {1'b0, frame_err_s} + {1'b0, bad_byte_s};

  // Checker next-state logic: hunt/lock with self-synchronising history.
  always_comb begin
    chk_state_d    = chk_state_q;
    hist_d         = hist_q;
    fill_d         = fill_q;
    consec_d       = consec_q;
    locked_d       = locked_q;
    err_d          = 1'b0;
    bits_checked_d = bits_checked_q;
    bit_errors_d   = bit_errors_q;
    if (accept_s) begin
      // The received bit always enters the history, so a relock only needs
      // eleven fresh bits regardless of what was received before.
      hist_d = {bit_r_s, hist_q[10:1]};
      case (chk_state_q)
        CHK_HUNT: begin
          fill_d = fill_q + 4'd1;
          if (fill_q == FILL_LAST) begin
            chk_state_d = CHK_LOCKED;
            locked_d    = 1'b1;
            consec_d    = 4'd0;
          end else begin
            chk_state_d = CHK_HUNT;
          end
        end
        CHK_LOCKED: begin
          bits_checked_d = sat_inc(bits_checked_q, 2'd1);
          if (bit_r_s == pred_s) begin
            consec_d = 4'd0;
          end else begin
            bit_errors_d = sat_inc(bit_errors_q, 2'd1);
            err_d        = 1'b1;
            consec_d     = consec_q + 4'd1;
            if (consec_q + 4'd1 == LOSS_CNT) begin
              chk_state_d = CHK_HUNT;
              locked_d    = 1'b0;
              fill_d      = 4'd0;
            end else begin
              chk_state_d = CHK_LOCKED;
            end
          end
        end
        default: begin
          chk_state_d = CHK_HUNT;
          locked_d    = 1'b0;
          fill_d      = 4'd0;
        end
      endcase
    end else begin
      chk_state_d = chk_state_q;
    end
  end

  // Bad-character counter: framing errors and non-'0'/'1' bytes.
  always_comb begin
    bad_chars_d = sat_inc(bad_chars_q, bad_inc_s);
  end

  // Checker state and statistics registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chk_state_q    <= CHK_HUNT;
      hist_q         <= 11'd0;
      fill_q         <= 4'd0;
      consec_q       <= 4'd0;
      locked_q       <= 1'b0;
      err_q          <= 1'b0;
      bits_checked_q <= '0;
      bit_errors_q   <= '0;
      bad_chars_q    <= '0;
    end else begin
      chk_state_q    <= chk_state_d;
      hist_q         <= hist_d;
      fill_q         <= fill_d;
      consec_q       <= consec_d;
      locked_q       <= locked_d;
      err_q          <= err_d;
      bits_checked_q <= bits_checked_d;
      bit_errors_q   <= bit_errors_d;
      bad_chars_q    <= bad_chars_d;
    end
  end

  assign o_rx_dv        = rx_dv_q;
  assign o_rx_byte      = rx_byte_q;
  assign o_locked       = locked_q;
  assign o_err_pulse    = err_q;
  assign o_bits_checked = bits_checked_q;
  assign o_bit_errors   = bit_errors_q;
  assign o_bad_chars    = bad_chars_q;

endmodule
